// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexed common-anode 7-segment scanner. Lights one digit at a
//   time with a blanking gap before each digit and snapshots the digit
//   values once per frame so a frame never shows a torn count.
//
//   Optional feature macro: LEADING_ZERO_BLANK_EN (suppress leading zeros).
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   enable      1 = scan, 0 = display dark and scanner idle
//   digits      digit k at [k*DIGIT_BITS +: DIGIT_BITS], k=0 rightmost
//   dp_mask     1 = light decimal point on digit k
//   an_n        anode enables, active-low (one-hot-low or all 1)
//   seg_n       segments {g,f,e,d,c,b,a}, active-low
//   dp_n        decimal point, active-low
//   digit_idx   index of the digit currently blanking/driving
//   frame_tick  1-cycle pulse in the first cycle of each frame
module seven_seg_scanner #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIGIT_BITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 enable,
  input  logic [NUM_DIGITS*DIGIT_BITS-1:0]                     digits,
  input  logic [NUM_DIGITS-1:0]                                dp_mask,
  output logic [NUM_DIGITS-1:0]                                an_n,
  output logic [6:0]                                           seg_n,
  output logic                                                 dp_n,
  output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
  output logic                                                 frame_tick
);

  localparam int unsigned IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned TMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned GW   = (DIGIT_BITS > 4) ? DIGIT_BITS : 4;
  localparam int unsigned SW   = NUM_DIGITS * DIGIT_BITS;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] DRIVE = 2'd2;

  logic [1:0]            state, state_nxt;
  logic [TW-1:0]         timer, timer_nxt;
  logic [IW-1:0]         idx_nxt;
  logic [SW-1:0]         snap, snap_nxt;
  logic [NUM_DIGITS-1:0] dp_snap, dp_snap_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;
  logic                  tick_nxt;
  logic [6:0]            cur_glyph_c;

  // Active-low glyph lookup; values above 15 show a dash.
  function automatic logic [6:0] glyph(input logic [DIGIT_BITS-1:0] d);
    logic [GW-1:0] v;
    v     = GW'(d);
    glyph = 7'h3F;
    if ((v >> 4) == '0) begin
      case (v[3:0])
        4'h0: glyph = 7'h40;
        4'h1: glyph = 7'h79;
        4'h2: glyph = 7'h24;
        4'h3: glyph = 7'h30;
        4'h4: glyph = 7'h19;
        4'h5: glyph = 7'h12;
        4'h6: glyph = 7'h02;
        4'h7: glyph = 7'h78;
        4'h8: glyph = 7'h00;
        4'h9: glyph = 7'h10;
        4'hA: glyph = 7'h08;
        4'hB: glyph = 7'h03;
        4'hC: glyph = 7'h46;
        4'hD: glyph = 7'h21;
        4'hE: glyph = 7'h06;
        default: glyph = 7'h0E;
      endcase
    end
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // lead_zero_c[k]: snapshot digits k..top are all zero (digit 0 never blanked).
  logic [NUM_DIGITS-1:0] lead_zero_c;
  logic                  zero_run;
  always_comb begin
    lead_zero_c = '0;
    zero_run    = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run       = zero_run && (snap[k*DIGIT_BITS +: DIGIT_BITS] == '0);
      lead_zero_c[k] = zero_run;
    end
  end

  always_comb begin
    cur_glyph_c = glyph(snap[digit_idx*DIGIT_BITS +: DIGIT_BITS]);
    if (lead_zero_c[digit_idx]) cur_glyph_c = 7'h7F;
  end
`else
  always_comb begin
    cur_glyph_c = glyph(snap[digit_idx*DIGIT_BITS +: DIGIT_BITS]);
  end
`endif

  // Next-state and next-output logic; outputs default to dark.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    idx_nxt     = digit_idx;
    snap_nxt    = snap;
    dp_snap_nxt = dp_snap;
    an_nxt      = '1;
    seg_nxt     = 7'h7F;
    dp_nxt      = 1'b1;
    tick_nxt    = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      timer_nxt = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt   = BLANK;
          timer_nxt   = TW'(BLANK_CYCLES - 1);
          idx_nxt     = '0;
          snap_nxt    = digits;
          dp_snap_nxt = dp_mask;
          tick_nxt    = 1'b1;
        end
        BLANK: begin
          if (timer == '0) begin
            state_nxt = DRIVE;
            timer_nxt = TW'(REFRESH_DIV - 1);
            an_nxt    = ~(NUM_DIGITS'(1) << digit_idx);
            seg_nxt   = cur_glyph_c;
            dp_nxt    = ~dp_snap[digit_idx];
          end else begin
            timer_nxt = timer - TW'(1);
          end
        end
        DRIVE: begin
          if (timer == '0) begin
            state_nxt = BLANK;
            timer_nxt = TW'(BLANK_CYCLES - 1);
            if (digit_idx == IW'(NUM_DIGITS - 1)) begin
              // Frame wrap: re-snapshot so the new frame is self-consistent.
              idx_nxt     = '0;
              snap_nxt    = digits;
              dp_snap_nxt = dp_mask;
              tick_nxt    = 1'b1;
            end else begin
              idx_nxt = digit_idx + IW'(1);
            end
          end else begin
            timer_nxt = timer - TW'(1);
            an_nxt    = an_n;
            seg_nxt   = seg_n;
            dp_nxt    = dp_n;
          end
        end
        default: begin
          state_nxt = IDLE;
          timer_nxt = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // State, snapshot and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      digit_idx  <= '0;
      snap       <= '0;
      dp_snap    <= '0;
      an_n       <= '1;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      digit_idx  <= idx_nxt;
      snap       <= snap_nxt;
      dp_snap    <= dp_snap_nxt;
      an_n       <= an_nxt;
      seg_n      <= seg_nxt;
      dp_n       <= dp_nxt;
      frame_tick <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner
//   Directed bench for seven_seg_scanner with NUM_DIGITS=4, REFRESH_DIV=4,
//   BLANK_CYCLES=1 (20-cycle frame). Expected per-cycle outputs come from
//   hand-written glyph words and the frame position (5 cycles per digit:
//   1 blank then 4 drive).
module tb_seven_seg_scanner;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;

  // Glyph words {digit3, digit2, digit1, digit0}, hand-computed.
  localparam logic [27:0] G_1234 = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [27:0] G_9999 = {7'h10, 7'h10, 7'h10, 7'h10};
  localparam logic [27:0] G_ABEF = {7'h08, 7'h03, 7'h06, 7'h0E};
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [27:0] G_0050 = {7'h7F, 7'h7F, 7'h12, 7'h40};
`else
  localparam logic [27:0] G_0050 = {7'h40, 7'h40, 7'h12, 7'h40};
`endif

  seven_seg_scanner #(
    .NUM_DIGITS  (4),
    .DIGIT_BITS  (4),
    .REFRESH_DIV (4),
    .BLANK_CYCLES(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .digits    (digits),
    .dp_mask   (dp_mask),
    .an_n      (an_n),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .digit_idx (digit_idx),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " an_n"}, 32'(an_n), 32'hF);
    check({tag, " seg_n"}, 32'(seg_n), 32'h7F);
    check({tag, " dp_n"}, 32'(dp_n), 32'h1);
    check({tag, " idx"}, 32'(digit_idx), 32'h0);
    check({tag, " tick"}, 32'(frame_tick), 32'h0);
  endtask

  // Check one cycle of a frame at position c (0..19).
  task automatic check_cycle(input string name, input int c,
                             input logic [27:0] gl, input logic [3:0] dpm);
    int   d;
    int   pos;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    string      t;
    d   = c / 5;
    pos = c % 5;
    t   = $sformatf("%s c%0d", name, c);
    if (pos == 0) begin
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
    end else begin
      exp_an  = ~(4'b0001 << d);
      exp_seg = gl[d*7 +: 7];
      exp_dp  = ~dpm[d];
    end
    check({t, " an_n"}, 32'(an_n), 32'(exp_an));
    check({t, " seg_n"}, 32'(seg_n), 32'(exp_seg));
    check({t, " dp_n"}, 32'(dp_n), 32'(exp_dp));
    check({t, " idx"}, 32'(digit_idx), 32'(d));
    check({t, " tick"}, 32'(frame_tick), 32'(c == 0));
  endtask

  initial begin
    // 1. Reset with enable high keeps everything dark.
    rst     = 1'b1;
    enable  = 1'b1;
    digits  = 16'h1234;
    dp_mask = 4'b0010;
    step();
    check_idle("rst1");
    step();
    check_idle("rst2");
    rst    = 1'b0;
    enable = 1'b0;
    step();
    check_idle("idle");

    // 2/3. Frame of 1234; digits change mid-frame but snapshot holds.
    enable = 1'b1;
    step();
    for (int c = 0; c < 20; c++) begin
      check_cycle("f1234", c, G_1234, 4'b0010);
      if (c == 6) digits = 16'h9999;
      step();
    end
    for (int c = 0; c < 20; c++) begin
      check_cycle("f9999", c, G_9999, 4'b0010);
      step();
    end

    // 4. Disable during DRIVE of digit 2, then restart at digit 0.
    for (int c = 0; c <= 12; c++) begin
      check_cycle("fdis", c, G_9999, 4'b0010);
      if (c == 12) enable = 1'b0;
      step();
    end
    check_idle("dis1");
    step();
    check_idle("dis2");

    // 6. Three frames of ABEF; tick period and one-hot anodes per cycle.
    digits  = 16'hABEF;
    dp_mask = 4'b0000;
    enable  = 1'b1;
    step();
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 20; c++) begin
        check_cycle($sformatf("fabef%0d", f), c, G_ABEF, 4'b0000);
        if (f == 2 && c == 15) begin
          digits  = 16'h0050;
          dp_mask = 4'b1000;
        end
        step();
      end
    end

    // 5. Leading zeros (macro dependent); dp still follows mask; rst mid-DRIVE.
    for (int c = 0; c <= 7; c++) begin
      check_cycle("f0050", c, G_0050, 4'b1000);
      if (c == 7) rst = 1'b1;
      step();
    end
    check_idle("rstmid");
    rst = 1'b0;
    step();
    check_cycle("restart", 0, G_0050, 4'b1000);
    step();
    check_cycle("restart", 1, G_0050, 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
